vga_fb_scheduler: RTL and testbench
===================================

Name: vga_fb_scheduler

Overview:
- Scheduler that shares one single-port 8-bit frame memory between two users: VGA scan-out (line prefetch) and a pixel writer (drawing engine/CPU).
- Sits between the 640x480 VGA timing generator (consumes its hc/vc counters) and the frame RAM.
- Holds a 160x120 framebuffer, 4x4 pixel replication. Prefetches each source row into an internal line buffer during horizontal blanking; the writer gets every other memory cycle.
- Drives the 8-bit RGB332 colour into the VGA generator's colour inputs.

Parameters:
COLS, 160, source pixels per row (= 640/SCALE)
ROWS, 120, source rows (= 480/SCALE)
SCALE_LOG2, 2, log2 of pixel replication factor
FETCH_START, 640, hc value of first fetch read cycle
FB_AW, 15, frame memory address width

Ports:
vgaclk  in  1  pixel clock (25.175 MHz)
rst  in  1  synchronous reset, active-low
hc  in  10  horizontal counter from VGA timing block, 0..799
vc  in  10  vertical counter from VGA timing block, 0..524
wr_req  in  1  writer request; hold with stable wr_addr/wr_data until wr_ack
wr_addr  in  FB_AW  writer pixel address (row*COLS+col)
wr_data  in  8  writer pixel RGB332
wr_ack  out  1  one-cycle pulse: write committed
mem_addr  out  FB_AW  frame memory address (registered)
mem_we  out  1  frame memory write enable (registered)
mem_re  out  1  frame memory read enable (registered)
mem_wdata  out  8  frame memory write data (registered)
mem_rdata  in  8  read data, valid the cycle after mem_re is asserted
pix_red  out  3  to VGA input_red
pix_green  out  3  to VGA input_green
pix_blue  out  2  to VGA input_blue
lb_valid  out  1  line buffer holds a complete row

Behaviour:
- Reset (rst=0 at a vgaclk edge): state IDLE, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, wr_ack=0, lb_valid=0, col counter=0. Line buffer contents are not reset. Reset mid-fetch aborts the fetch; lb_valid stays 0 until the next complete fetch.
- Fetch line: vc==524 (fetch row 0) or vc<479 with vc[1:0]==3 (fetch row (vc+1)>>2). Every other line is a non-fetch line.
- FSM states:
  - IDLE -> FETCH: on the edge where hc==FETCH_START-1 on a fetch line. Latch row.
  - FETCH: mem_re=1 during hc 640..799; mem_addr=row*COLS+col; col increments 0..159.
  - FETCH -> DRAIN: after col 159 is issued.
  - DRAIN: one cycle. Captures the final mem_rdata. Sets lb_valid=1 -> IDLE.
- Read pipeline: mem_rdata present in cycle k+1 is written to linebuf[col issued in cycle k]. Entry 0 is written at hc 641; entry 159 is written at hc 0 of the next line.
- Line buffer: 160x8 register array; separate write and read paths.
  - {pix_red,pix_green,pix_blue} = linebuf[hc>>SCALE_LOG2] when hc<640, vc<480 and lb_valid=1.
  - Otherwise 0. Combinational from hc.
- Writer arbitration: a memory cycle belongs to the writer whenever the FSM is not issuing a fetch read (IDLE or DRAIN). Fetch has absolute priority.
  - wr_req=1 in a writer cycle: next edge registers mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
  - wr_ack is low in the following cycle, even if wr_req stays high. Max throughput is 1 write per 2 cycles.
  - wr_addr >= COLS*ROWS: mem_we stays 0, wr_ack still pulses (write dropped).
- Simultaneous events:
  - wr_req asserted at the fetch start edge: wr_req waits; no ack during FETCH.
  - Worst-case writer latency is 162 cycles.
- Arithmetic:
  - row*COLS is computed as (row<<7)+(row<<5), truncated to FB_AW bits.
  - col is 8 bits and saturates at 159; it is cleared on FETCH entry.
- mem_we and mem_re are never both 1.

Test Plan:
- Reset: hold rst=0 3 cycles mid-FETCH (hc=700, vc=3) -> mem_re=0, wr_ack=0, lb_valid=0, all pix_*=0. Release rst -> no fetch until the next fetch line.
- Row-0 prefetch: preload mem[i]=i[7:0] for i<160; run vc=524 -> mem_re high exactly hc 640..799 with mem_addr 0..159. At vc=0: pix output at hc=4*k equals k for k=0..159; at hc=3 it equals 0.
- Row change: at vc=3, hc=640 -> mem_addr=160 (row 1). vc=1 and vc=2 produce no mem_re.
- Writer priority: hold wr_req=1, wr_addr=200, wr_data=0xE3 from vc=3, hc=630 -> acks at hc 631,633,...,639 only. Next ack arrives after DRAIN (hc=1 of vc=4); mem_we never overlaps mem_re.
- Out-of-range write: wr_addr=19200 -> wr_ack pulses once, mem_we stays 0.
- Back-to-back writes with wr_req held -> wr_ack pulses every 2nd cycle; mem_wdata matches each presented wr_data.

Source files
------------

// File: rtl/vga_fb_scheduler.sv
// Shares one single-port frame memory between VGA line prefetch and a pixel writer.
// 160x120 RGB332 framebuffer shown at 4x replication from an internal line buffer.
module vga_fb_scheduler #(
  parameter int COLS        = 160,
  parameter int ROWS        = 120,
  parameter int SCALE_LOG2  = 2,
  parameter int FETCH_START = 640,
  parameter int FB_AW       = 15
) (
  input  logic             vgaclk,
  input  logic             rst,
  input  logic [9:0]       hc,
  input  logic [9:0]       vc,
  input  logic             wr_req,
  input  logic [FB_AW-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  output logic             wr_ack,
  output logic [FB_AW-1:0] mem_addr,
  output logic             mem_we,
  output logic             mem_re,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  output logic [2:0]       pix_red,
  output logic [2:0]       pix_green,
  output logic [1:0]       pix_blue,
  output logic             lb_valid
);

  localparam int COL_W = 8;
  localparam int ROW_W = 7;
  localparam int H_VIS = COLS << SCALE_LOG2;
  localparam int V_VIS = ROWS << SCALE_LOG2;
  localparam logic [FB_AW-1:0] FB_SIZE = FB_AW'(COLS * ROWS);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [FB_AW-1:0]   mem_addr_q, mem_addr_d;
  logic               mem_we_q, mem_we_d;
  logic               mem_re_q, mem_re_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;
  logic               wr_ack_q, wr_ack_d;
  logic               lb_valid_q, lb_valid_d;
  logic               rd_vld_q, rd_vld_d;
  logic [COL_W-1:0]   rd_col_q, rd_col_d;
  logic [7:0]         linebuf_q [0:COLS-1];

  logic               fetch_line;
  logic [ROW_W-1:0]   fetch_row;
  logic               start_fetch;
  logic [COL_W-1:0]   pix_col;
  logic [7:0]         pix;

  // row*COLS as shift-add: 160 = 128 + 32
  function automatic logic [FB_AW-1:0] row_base(input logic [ROW_W-1:0] r);
    return (FB_AW'(r) << 7) + (FB_AW'(r) << 5);
  endfunction

  // The last line of each replicated group (and the final line of the frame) loads the next row
  assign fetch_line  = (vc == 10'd524) ||
                       ((vc < 10'(V_VIS - 1)) && (&vc[SCALE_LOG2-1:0]));
  assign fetch_row   = (vc == 10'd524) ? '0 : ROW_W'((vc + 10'd1) >> SCALE_LOG2);
  assign start_fetch = (state_q == IDLE) && fetch_line && (hc == 10'(FETCH_START - 1));

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    wr_ack_d    = 1'b0;
    lb_valid_d  = lb_valid_q;
    rd_vld_d    = mem_re_q;
    rd_col_d    = col_q;

    case (state_q)
      IDLE: begin
        if (start_fetch) begin
          state_d    = FETCH;
          row_d      = fetch_row;
          col_d      = '0;
          mem_re_d   = 1'b1;
          mem_addr_d = row_base(fetch_row);
        end
      end
      FETCH: begin
        if (col_q == COL_W'(COLS - 1)) begin
          state_d = DRAIN;
        end else begin
          col_d      = col_q + COL_W'(1);
          mem_re_d   = 1'b1;
          mem_addr_d = row_base(row_q) + FB_AW'(col_q + COL_W'(1));
        end
      end
      DRAIN: begin
        state_d    = IDLE;
        lb_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Writer owns every cycle the fetch does not; the ack cycle itself is always skipped
    if ((state_q != FETCH) && !start_fetch && wr_req && !wr_ack_q) begin
      wr_ack_d    = 1'b1;
      mem_we_d    = (wr_addr < FB_SIZE);
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
    end
  end

  always_ff @(posedge vgaclk) begin
    if (!rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      lb_valid_q  <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_col_q    <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ack_q    <= wr_ack_d;
      lb_valid_q  <= lb_valid_d;
      rd_vld_q    <= rd_vld_d;
      rd_col_q    <= rd_col_d;
    end
  end

  // Read data lands one cycle after its address; store it under the column that issued it
  always_ff @(posedge vgaclk) begin
    if (rd_vld_q) begin
      linebuf_q[rd_col_q] <= mem_rdata;
    end
  end

  assign pix_col = COL_W'(hc >> SCALE_LOG2);

  always_comb begin
    pix = 8'h00;
    if ((hc < 10'(H_VIS)) && (vc < 10'(V_VIS)) && lb_valid_q) begin
      pix = linebuf_q[pix_col];
    end
  end

  assign {pix_red, pix_green, pix_blue} = pix;
  assign wr_ack    = wr_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_wdata = mem_wdata_q;
  assign lb_valid  = lb_valid_q;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Bench for vga_fb_scheduler: acts as timing generator and frame RAM, and checks every
// cycle against a line-level model of fetch windows, writer slots and displayed pixels.
module tb_vga_fb_scheduler;

  logic        vgaclk;
  logic        rst;
  logic [9:0]  hc, vc;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic [14:0] mem_addr;
  logic        mem_we, mem_re;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [2:0]  pix_red, pix_green;
  logic [1:0]  pix_blue;
  logic        lb_valid;

  vga_fb_scheduler dut (
    .vgaclk(vgaclk), .rst(rst), .hc(hc), .vc(vc),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
    .lb_valid(lb_valid)
  );

  initial vgaclk = 1'b0;
  always #5 vgaclk = ~vgaclk;

  int n_asserts;
  int n_fail;

  // Reference model state
  logic [7:0]  ref_mem [0:32767];
  logic [7:0]  m_lb [0:159];
  bit          m_fetch, m_drain, m_lbv, m_ack, m_we;
  int          m_row;
  logic [14:0] m_wa;
  logic [7:0]  m_wd;

  // Timing-generator jump request and writer stimulus mode (0 drop, 1 random, 2 manual, 3 held)
  bit          jump;
  logic [9:0]  jump_h, jump_v;
  int          wr_mode;

  function automatic logic [7:0] pre_val(input int i);
    logic [31:0] t;
    t = 32'(i);
    if (i < 160) return t[7:0];
    t = 32'(i * 37 + 11) ^ (t >> 3);
    return t[7:0];
  endfunction

  // Frame RAM: one-cycle read latency
  logic [7:0] fb_mem [0:32767];
  initial begin
    for (int i = 0; i < 32768; i++) fb_mem[i] = pre_val(i);
    forever begin
      @(posedge vgaclk);
      if (mem_we === 1'b1) fb_mem[mem_addr] <= mem_wdata;
      if (mem_re === 1'b1) mem_rdata <= fb_mem[mem_addr];
    end
  end

  function automatic bit is_fetch_line(input logic [9:0] v);
    return (v == 10'd524) || ((v < 10'd479) && (v[1:0] == 2'b11));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (hc=%0d vc=%0d)", tag, obs, exp_v, hc, vc);
    end
  endtask

  task automatic cyc();
    logic [9:0]  ph, pv;
    logic [14:0] pa;
    logic [7:0]  pd;
    logic [31:0] exp_pix;
    bit          prst, preq, pack, pbusy;
    ph = hc; pv = vc; prst = rst; preq = wr_req; pa = wr_addr; pd = wr_data;
    pack = m_ack; pbusy = m_fetch;
    @(posedge vgaclk);
    #1;
    if (jump) begin
      hc = jump_h; vc = jump_v; jump = 0;
    end else if (hc == 10'd799) begin
      hc = 0; vc = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
    end else begin
      hc = hc + 10'd1;
    end

    if (!prst) begin
      m_fetch = 0; m_drain = 0; m_lbv = 0; m_ack = 0; m_we = 0;
    end else begin
      if (m_drain) begin m_drain = 0; m_lbv = 1; end
      if (m_fetch && ph == 10'd799) begin
        m_fetch = 0; m_drain = 1;
        for (int k = 0; k < 160; k++) m_lb[k] = ref_mem[m_row * 160 + k];
      end else if (!m_fetch && ph == 10'd639 && is_fetch_line(pv)) begin
        m_fetch = 1;
        m_row = (pv == 10'd524) ? 0 : (int'(pv) + 1) / 4;
      end
      m_ack = preq && !pack && !pbusy && !m_fetch;
      m_we  = m_ack && (pa < 15'd19200);
      if (m_ack) begin m_wa = pa; m_wd = pd; end
      if (m_we) ref_mem[pa] = pd;
    end
    #1;

    chk("mem_re", 32'(mem_re), 32'(m_fetch));
    if (m_fetch) chk("fetch_addr", 32'(mem_addr), 32'(m_row * 160 + int'(hc) - 640));
    chk("wr_ack", 32'(wr_ack), 32'(m_ack));
    chk("mem_we", 32'(mem_we), 32'(m_we));
    if (m_we) begin
      chk("wr_addr", 32'(mem_addr), 32'(m_wa));
      chk("wr_wdata", 32'(mem_wdata), 32'(m_wd));
    end
    chk("we_re_excl", 32'(mem_we & mem_re), 32'(0));
    chk("lb_valid", 32'(lb_valid), 32'(m_lbv));
    exp_pix = (hc < 10'd640 && vc < 10'd480 && m_lbv) ? 32'(m_lb[int'(hc) / 4]) : 32'(0);
    chk("pix", 32'({pix_red, pix_green, pix_blue}), exp_pix);

    case (wr_mode)
      0: if (wr_ack) wr_req = 0;
      1: begin
        if (wr_ack) wr_req = 0;
        if (!wr_req && $urandom_range(0, 2) == 0) begin
          wr_req  = 1;
          wr_addr = 15'($urandom_range(160, 20000));
          wr_data = 8'($urandom);
        end
      end
      3: if (wr_ack) begin
        wr_addr = 15'($urandom_range(160, 19199));
        wr_data = 8'($urandom);
      end
      default: ;
    endcase
  endtask

  task automatic goto_pos(input logic [9:0] h, input logic [9:0] v);
    jump = 1; jump_h = h; jump_v = v;
    cyc();
  endtask

  task automatic run_to(input logic [9:0] h, input logic [9:0] v);
    int n;
    n = 0;
    while (!(hc == h && vc == v) && n < 5000) begin cyc(); n++; end
    chk("reach_pos", {12'd0, vc, hc}, {12'd0, v, h});
  endtask

  int re_cnt, ack_cnt, we_cnt, n;
  int r;
  logic [9:0] fv;

  initial begin
    n_asserts = 0; n_fail = 0;
    rst = 0; hc = 10'd690; vc = 10'd3;
    wr_req = 0; wr_addr = 0; wr_data = 0;
    jump = 0; wr_mode = 2;
    m_fetch = 0; m_drain = 0; m_lbv = 0; m_ack = 0; m_we = 0; m_row = 0;
    m_wa = 0; m_wd = 0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = pre_val(i);

    // Power-on reset values
    repeat (3) cyc();
    chk("rst_mem_re", 32'(mem_re), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_wr_ack", 32'(wr_ack), 0);
    chk("rst_lb_valid", 32'(lb_valid), 0);
    chk("rst_pix", 32'({pix_red, pix_green, pix_blue}), 0);

    // One write, then reset in the middle of the row-1 fetch
    rst = 1;
    goto_pos(10'd560, 10'd3);
    wr_req = 1; wr_addr = 15'd19000; wr_data = 8'h5A;
    cyc();
    chk("pre_ack", 32'(wr_ack), 1);
    chk("pre_wdata", 32'(mem_wdata), 32'h5A);
    wr_req = 0;
    run_to(10'd700, 10'd3);
    chk("midfetch_re", 32'(mem_re), 1);
    rst = 0;
    repeat (3) cyc();
    chk("mid_rst_re", 32'(mem_re), 0);
    chk("mid_rst_ack", 32'(wr_ack), 0);
    chk("mid_rst_lbv", 32'(lb_valid), 0);
    chk("mid_rst_pix", 32'({pix_red, pix_green, pix_blue}), 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    chk("mid_rst_wdata", 32'(mem_wdata), 0);
    rst = 1;
    re_cnt = 0; n = 0;
    while (!(vc == 10'd4 && hc == 10'd50) && n < 400) begin
      cyc(); n++;
      if (mem_re) re_cnt++;
    end
    chk("no_fetch_after_rst", 32'(re_cnt), 0);

    // Row-0 prefetch on vc=524 and display on vc=0
    wr_mode = 1;
    goto_pos(10'd600, 10'd524);
    re_cnt = 0; n = 0;
    while (!(vc == 10'd0 && hc == 10'd799) && n < 2000) begin
      cyc(); n++;
      if (vc == 10'd524 && mem_re) re_cnt++;
      if (vc == 10'd524 && hc == 10'd640) chk("row0_first_addr", 32'(mem_addr), 0);
      if (vc == 10'd524 && hc == 10'd799) chk("row0_last_addr", 32'(mem_addr), 159);
      if (vc == 10'd0 && hc < 10'd640 && hc[1:0] == 2'b00)
        chk("row0_pix", 32'({pix_red, pix_green, pix_blue}), 32'(hc >> 2));
      if (vc == 10'd0 && hc == 10'd3) chk("row0_pix_hc3", 32'({pix_red, pix_green, pix_blue}), 0);
    end
    chk("row0_re_count", 32'(re_cnt), 160);

    // Lines 1 and 2 must not fetch
    re_cnt = 0; n = 0;
    while (!(vc == 10'd3 && hc == 10'd600) && n < 3000) begin
      cyc(); n++;
      if ((vc == 10'd1 || vc == 10'd2) && mem_re) re_cnt++;
    end
    chk("no_fetch_vc1_2", 32'(re_cnt), 0);

    // Writer held across the fetch window
    wr_mode = 0;
    run_to(10'd630, 10'd3);
    wr_mode = 2; wr_req = 1; wr_addr = 15'd200; wr_data = 8'hE3;
    n = 0;
    while (!(vc == 10'd4 && hc == 10'd1) && n < 400) begin
      cyc(); n++;
      if (vc == 10'd3 && hc >= 10'd631 && hc <= 10'd639) chk("prio_ack", 32'(wr_ack), 32'(hc[0]));
      if (vc == 10'd3 && hc == 10'd640) chk("row1_addr", 32'(mem_addr), 160);
    end
    chk("drain_ack", 32'(wr_ack), 1);

    // Back-to-back writes with changing data
    wr_mode = 3;
    run_to(10'd100, 10'd4);
    ack_cnt = 0;
    repeat (40) begin
      cyc();
      if (wr_ack) ack_cnt++;
    end
    chk("b2b_ack_count", 32'(ack_cnt), 20);

    // Out-of-range write is acknowledged but dropped
    wr_mode = 0;
    run_to(10'd150, 10'd4);
    wr_mode = 2; wr_req = 1; wr_addr = 15'd19200; wr_data = 8'hFF;
    ack_cnt = 0; we_cnt = 0;
    repeat (10) begin
      cyc();
      if (wr_ack) begin ack_cnt++; wr_req = 0; end
      if (mem_we) we_cnt++;
    end
    chk("oor_ack_count", 32'(ack_cnt), 1);
    chk("oor_we_count", 32'(we_cnt), 0);

    // Randomised writes over a series of row fetches
    wr_mode = 1;
    goto_pos(10'd600, 10'd7);
    run_to(10'd700, 10'd8);
    for (int it = 0; it < 8; it++) begin
      r = int'($urandom_range(0, 119));
      fv = (r == 0) ? 10'd524 : 10'(4 * r - 1);
      goto_pos(10'd600, fv);
      run_to(10'd700, (r == 0) ? 10'd0 : 10'(4 * r));
    end
    goto_pos(10'd600, 10'd475);
    run_to(10'd700, 10'd476);

    // vc=479 is not a fetch line
    goto_pos(10'd600, 10'd479);
    re_cnt = 0; n = 0;
    while (!(vc == 10'd480 && hc == 10'd200) && n < 1000) begin
      cyc(); n++;
      if (mem_re) re_cnt++;
    end
    chk("no_fetch_vc479", 32'(re_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
